wavetable_nco: RTL
==================

Name: wavetable_nco

Overview:
Phase-accumulator oscillator that drives the 256-entry, 9-bit wavetable lookup. It acts as the address initiator for that lookup and consumes the returned level. Once per sample tick it advances phase, issues the table address, captures the level one cycle later, applies amplitude scaling, and emits one signed sample toward the DAC/mixer path. A gate input starts a note; on release the oscillator stops at the next phase wrap, so the note never ends mid-cycle.

Parameters:
PHASE_W, 24, phase accumulator and freq_word width; table_pos = phase[PHASE_W-1 -: 8]
AMP_W, 8, amplitude width; unsigned, 255 = near unity

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
gate  in  1  note gate, level-sensitive, synchronous to clk
sample_tick  in  1  one-cycle sample-rate strobe; may be high on consecutive cycles
freq_word  in  PHASE_W  phase increment per tick, sampled on tick
amp  in  AMP_W  amplitude, sampled in the scale stage
table_pos  out  8  wavetable address (registered)
table_level  in  9  wavetable data, two's complement; valid 1 cycle after table_pos
sample_out  out  9  scaled sample, two's complement
sample_valid  out  1  one-cycle pulse per tick
active  out  1  high when state != IDLE

Behaviour:
- Only clock is clk. Reset is asynchronous, active-low on rst_n. While rst_n is low: phase=0, state=IDLE, gate_q=0, pipeline valid bits=0, table_pos=0, sample_out=0, sample_valid=0, active=0.
- gate is registered into gate_q. rise = gate & ~gate_q; fall = ~gate & gate_q.
- States: IDLE, RUN, STOP.
  - IDLE -> RUN on rise. phase <= (tick ? freq_word : 0).
  - RUN -> STOP on fall.
  - STOP -> RUN on rise. No phase reset, to avoid a discontinuity.
  - STOP -> IDLE on a tick whose addition carries out of PHASE_W. That cycle: phase <= 0, and the sample is marked inactive.
- Phase update: on tick in RUN or STOP, phase <= phase + freq_word, modulo 2^PHASE_W. In IDLE, phase holds 0.
- Pipeline for a tick in cycle T. Stage valid and active bits travel in a shift register, so ticks on every cycle are supported.
  - T+1: phase and table_pos updated.
  - T+2: table_level valid.
  - End of T+2: product = signed(table_level) * {0,amp}, arithmetic shift right by 8, truncated to 9 bits. Forced to 0 if the stage active bit is 0.
  - T+3: sample_out updated, sample_valid=1 for exactly one cycle.
  - Latency from tick to sample_valid is 3 cycles.
- Ticks in IDLE still produce sample_valid with sample_out=0, keeping a constant sample rate.
- sample_out holds its value between valid pulses.
- Simultaneous rise and tick: handled as above, with the first sample at address phase[top] of freq_word. Simultaneous fall and tick in RUN: the tick advances phase and the state goes to STOP.
- amp=0 gives 0. amp=255 with level=255 gives 254. Scaling never overflows 9 bits.
- Reset asserted mid-operation drops in-flight samples; no sample_valid follows release of rst_n until a new tick.

Decomposition:
- Shared package/include: TABLE_AW=8, TABLE_DW=9, NCO state encoding (IDLE=2'd0, RUN=2'd1, STOP=2'd2), default PHASE_W.
- One natural sub-module: wavetable_amp_scale, a registered signed 9-bit x unsigned AMP_W multiply and shift.
- The wavetable lookup stays external; the NCO connects to it through table_pos and table_level.

Test Plan:
- Reset, gate=1, freq_word=24'h010000, tick every 4 cycles, table model level=pos, amp=255 -> table_pos 0,1,2,3..., sample_out = (pos*255)>>8, valid exactly 3 cycles after each tick.
- gate=0, ticks applied -> sample_valid pulses, sample_out=0, table_pos=0, active=0.
- freq_word=24'h400000, drop gate when table_pos=128 -> samples continue at 192, then wrap gives phase 0, state IDLE, active=0, wrap sample output 0.
- Tick high on 10 consecutive cycles in RUN -> 10 consecutive sample_valid cycles starting 3 cycles after the first tick, addresses consecutive.
- table_level=9'h100 (-256), amp=128 -> sample_out=9'h180 (-128). amp=0 -> 0. level=9'h0FF, amp=255 -> 9'h0FE.
- rst_n low while 2 samples in flight -> table_pos, sample_out, sample_valid go 0 immediately; no valid pulse after release until the next tick.

Source files
------------

// File: rtl/wavetable_nco_pkg.sv
// Shared constants and state encoding for the wavetable NCO and its scaling stage.
package wavetable_nco_pkg;

    localparam int TABLE_AW    = 8;
    localparam int TABLE_DW    = 9;
    localparam int PHASE_W_DEF = 24;
    localparam int AMP_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } nco_state_e;

endpackage

// File: rtl/wavetable_nco_if.sv
// Address/data bus between the NCO (master) and the external wavetable (slave).
interface wavetable_nco_if;
    import wavetable_nco_pkg::*;

    logic [TABLE_AW-1:0] table_pos;
    logic [TABLE_DW-1:0] table_level;

    modport master (output table_pos, input table_level);
    modport slave  (input table_pos, output table_level);

endinterface

// File: rtl/wavetable_amp_scale.sv
// Registered signed level times unsigned amplitude, scaled down by 2^8 into a 9-bit sample.
module wavetable_amp_scale
    import wavetable_nco_pkg::*;
#(
    parameter int AMP_W = AMP_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic                active_i,
    input  logic [TABLE_DW-1:0] level_i,
    input  logic [AMP_W-1:0]    amp_i,
    output logic [TABLE_DW-1:0] sample_o,
    output logic                valid_o
);

    localparam int PROD_W = TABLE_DW + AMP_W + 1;

    logic signed [PROD_W-1:0] prod;
    logic [TABLE_DW-1:0]      sample_d;
    logic [TABLE_DW-1:0]      sample_q;
    logic                     valid_q;
    logic                     unused_prod_bits;

    // Zero-extending amp keeps it non-negative, so the product never exceeds 9 bits after the shift.
    assign prod             = $signed(level_i) * $signed({1'b0, amp_i});
    assign sample_d         = active_i ? prod[TABLE_DW+7:8] : '0;
    assign unused_prod_bits = ^{prod[PROD_W-1:TABLE_DW+8], prod[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                sample_q <= sample_d;
            end
        end
    end

    assign sample_o = sample_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/wavetable_nco.sv
// Gated phase-accumulator oscillator: addresses the wavetable once per tick and emits scaled samples.
module wavetable_nco
    import wavetable_nco_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int AMP_W   = AMP_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                gate,
    input  logic                sample_tick,
    input  logic [PHASE_W-1:0]  freq_word,
    input  logic [AMP_W-1:0]    amp,
    wavetable_nco_if.master     tbl,
    output logic [TABLE_DW-1:0] sample_out,
    output logic                sample_valid,
    output logic                active
);

    nco_state_e           state_q;
    nco_state_e           state_d;
    logic [PHASE_W-1:0]   phase_q;
    logic [PHASE_W-1:0]   phase_d;
    logic                 gate_q;
    logic [TABLE_AW-1:0]  pos_q;
    logic [1:0]           vld_q;
    logic [1:0]           act_q;
    logic                 act_d;
    logic                 rise;
    logic                 fall;
    logic [PHASE_W:0]     sum_w;

    assign rise  = gate & ~gate_q;
    assign fall  = ~gate & gate_q;
    assign sum_w = {1'b0, phase_q} + {1'b0, freq_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A release only ends the note once the accumulator carries out, so the waveform finishes its cycle.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (rise) begin
                    state_d = RUN;
                    phase_d = sample_tick ? freq_word : '0;
                end
            end
            RUN: begin
                if (sample_tick) phase_d = sum_w[PHASE_W-1:0];
                if (fall) state_d = STOP;
            end
            STOP: begin
                if (rise) begin
                    state_d = RUN;
                    if (sample_tick) phase_d = sum_w[PHASE_W-1:0];
                end else if (sample_tick) begin
                    if (sum_w[PHASE_W]) begin
                        state_d = IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = sum_w[PHASE_W-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        active = (state_q != IDLE);
    end

    assign act_d = sample_tick & (state_d != IDLE);

    // Valid/active bits ride a shift register alongside the table round trip, allowing back-to-back ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            gate_q  <= 1'b0;
            pos_q   <= '0;
            vld_q   <= '0;
            act_q   <= '0;
        end else begin
            phase_q <= phase_d;
            gate_q  <= gate;
            pos_q   <= phase_d[PHASE_W-1 -: TABLE_AW];
            vld_q   <= {vld_q[0], sample_tick};
            act_q   <= {act_q[0], act_d};
        end
    end

    assign tbl.table_pos = pos_q;

    wavetable_amp_scale #(
        .AMP_W (AMP_W)
    ) u_scale (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (vld_q[1]),
        .active_i (act_q[1]),
        .level_i  (tbl.table_level),
        .amp_i    (amp),
        .sample_o (sample_out),
        .valid_o  (sample_valid)
    );

endmodule
